// File: rtl/atanh_inv_4bit_stream.sv
// Streaming inverse-tanh lookup for 4-bit tanh codes: Q0.4 in, Q2.2 out.
// Two registered stages with valid/ready chaining and an output transfer counter.
module atanh_inv_4bit_stream #(
  parameter int TRUNC_BITS = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       In,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       Out1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic [CNT_W-1:0] xfer_count
);

  if (TRUNC_BITS < 0 || TRUNC_BITS > 2) begin : g_bad_trunc
    $error("atanh_inv_4bit_stream: TRUNC_BITS must be 0..2");
  end

  localparam logic [3:0] TRUNC_MASK = 4'hF << TRUNC_BITS;

  logic             r_s1_valid, r_s2_valid;
  logic [3:0]       r_s1_code, r_out;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s1_load, w_s2_load, w_xfer;
  logic [3:0]       w_raw;

  // round-half-up of 4*atanh(code/16)
  always_comb begin
    w_raw = 4'd0;
    case (r_s1_code)
      4'd0, 4'd1:                   w_raw = 4'd0;
      4'd2, 4'd3, 4'd4, 4'd5:       w_raw = 4'd1;
      4'd6, 4'd7, 4'd8:             w_raw = 4'd2;
      4'd9, 4'd10, 4'd11:           w_raw = 4'd3;
      4'd12:                        w_raw = 4'd4;
      4'd13, 4'd14:                 w_raw = 4'd5;
      default:                      w_raw = 4'd7;
    endcase
  end

  assign w_xfer    = r_s2_valid & out_ready;
  assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
  assign w_s1_load = ~r_s1_valid | w_s2_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_code  <= 4'd0;
      r_out      <= 4'd0;
      r_sat      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_s1_code <= In;
      end
      // a load during a transfer replaces the output with no bubble
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_out      <= w_raw & TRUNC_MASK;
        r_sat      <= (w_raw >= 4'd7);
      end else if (w_xfer) begin
        r_s2_valid <= 1'b0;
      end
      if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = w_s1_load;
  assign out_valid  = r_s2_valid;
  assign Out1       = r_out;
  assign sat_flag   = r_sat;
  assign xfer_count = r_cnt;

endmodule
